onehot_encode_buf: RTL
======================

ONEHOT_ENCODE_BUF -- requirements
Module: onehot_encode_buf

Interface
REQ-001 Parameter CNT_W, default 8, width of the error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 clr  input  1  synchronous clear of buffer and counter.
REQ-005 in_valid  input  1  In carries a word to accept.
REQ-006 In  input  4  one-hot word, as produced by the 2-to-4 decoder stage.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_valid  output  1  Out/out_err hold a buffered entry.
REQ-009 out_ready  input  1  consumer takes the head entry this cycle.
REQ-010 Out  output  2  encoded index of the head entry.
REQ-011 out_err  output  1  head entry came from a non-one-hot word.
REQ-012 err_cnt  output  CNT_W  count of accepted non-one-hot words.

Function
REQ-013 Encode rule: exactly one bit of In set -> index of that bit, err=0 (0001->0, 0010->1, 0100->2, 1000->3).
REQ-014 Zero or multiple bits set -> index of lowest set bit (0 if none), err=1 (0000->0/1, 0110->1/1, 1111->0/1).
REQ-015 Push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-016 Storage: 2-entry FIFO of {index[1:0], err}; order preserved.
REQ-017 Occupancy state machine: EMPTY, ONE, FULL.
REQ-018 EMPTY: push -> ONE; else stay.
REQ-019 ONE: push only -> FULL; pop only -> EMPTY; push and pop same cycle -> ONE, new entry becomes head next cycle.
REQ-020 FULL: pop -> ONE; no push possible.
REQ-021 in_ready = 1 in EMPTY and ONE, 0 in FULL; registered/state-derived only, no combinational path from out_ready.
REQ-022 out_valid = 1 in ONE and FULL; Out/out_err driven from head entry; stable while out_valid && !out_ready.
REQ-023 Latency: word pushed in cycle N into EMPTY appears on Out with out_valid=1 in cycle N+1.
REQ-024 Throughput: one word per cycle sustained with out_ready held high.
REQ-025 In ignored when in_valid=0 or in_ready=0; no state change.
REQ-026 err_cnt increments by 1 on each push with err=1; saturates at 2^CNT_W-1, never wraps.
REQ-027 err_cnt counts at push time, independent of pop.
REQ-028 clr=1: next state EMPTY, err_cnt=0; push and pop in that cycle discarded; clr has priority over all.
REQ-029 Out/out_err when out_valid=0: 0.

Reset
REQ-030 rst_n=0 asynchronously forces EMPTY, in_ready=0, out_valid=0, Out=0, out_err=0, err_cnt=0.
REQ-031 in_ready held 0 while rst_n=0; rises in first clk edge after release.
REQ-032 Reset mid-operation discards all buffered entries; no partial entry emitted after release.

Verification
REQ-033 Reset release, out_ready=1, push 0001,0010,0100,1000 back-to-back -> Out 0,1,2,3 on consecutive cycles starting 1 cycle after first push, out_err=0, err_cnt=0.
REQ-034 out_ready=0, push 0100,1000,0001 -> first two accepted, in_ready=0 after second, third held; Out=2 stable; raise out_ready -> Out 2, 3, then 0 after third accepted.
REQ-035 Push 0000, 0110, 1111 -> Out/out_err 0/1, 1/1, 0/1; err_cnt=3.
REQ-036 CNT_W=2, push 5 invalid words -> err_cnt 1,2,3,3,3.
REQ-037 State ONE, push 0010 and pop same cycle -> stays ONE, Out=1 next cycle, no entry lost or duplicated.
REQ-038 FULL with err_cnt=2, assert clr (also in_valid=1, out_ready=1) -> next cycle EMPTY, out_valid=0, err_cnt=0; async rst_n pulse mid-stream -> outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/onehot_encode_buf.sv
// onehot_encode_buf: one-hot to binary encoder with error flag, 2-entry output FIFO and saturating error counter
module onehot_encode_buf #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [3:0]       In,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       Out,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0] state;
  logic       rdy;
  logic [2:0] head, tail;
  logic [1:0] idx;
  logic       err, push, pop;
  always_comb begin
    idx = In[0] ? 2'd0 : In[1] ? 2'd1 : In[2] ? 2'd2 : In[3] ? 2'd3 : 2'd0;
    err = (In == 4'd0) || ((In & (In - 4'd1)) != 4'd0);
  end
  // rdy keeps in_ready low until the first edge after reset release
  assign in_ready  = rdy && state != FULL;
  assign out_valid = state != EMPTY;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign Out       = out_valid ? head[2:1] : 2'd0;
  assign out_err   = out_valid && head[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rdy     <= 1'b0;
      head    <= 3'd0;
      tail    <= 3'd0;
      err_cnt <= '0;
    end else begin
      rdy <= 1'b1;
      if (clr) begin
        state   <= EMPTY;
        err_cnt <= '0;
      end else begin
        state   <= push && !pop ? (state == EMPTY ? ONE : FULL) :
                   pop && !push ? (state == FULL ? ONE : EMPTY) : state;
        head    <= push && (state == EMPTY || (pop && state == ONE)) ? {idx, err} :
                   pop ? tail : head;
        tail    <= push && !pop && state == ONE ? {idx, err} : tail;
        err_cnt <= push && err && !(&err_cnt) ? err_cnt + CNT_W'(1) : err_cnt;
      end
    end
  end
endmodule
